// File: rtl/shervi_run_ctrl.sv
// Run controller for the SHER VI core: accepts an argument, pulses core reset,
// times the run until stop or budget expiry, and returns the result.
module shervi_run_ctrl #(
  parameter int unsigned           DATA_WIDTH = 16,
  parameter int unsigned           CNT_WIDTH  = 24,
  parameter logic [CNT_WIDTH-1:0]  MAX_CYCLES = 24'd1000000,
  parameter int unsigned           RST_CYCLES = 2
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_arg,
  output logic [DATA_WIDTH-1:0] core_arg,
  output logic                  core_reset,
  input  logic [DATA_WIDTH-1:0] core_return,
  input  logic                  core_stop,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_return,
  output logic [CNT_WIDTH-1:0]  rsp_cycles,
  output logic                  rsp_timeout,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, HOLD, RUN, DONE} state_e;

  localparam int unsigned          HW        = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HW-1:0]        HOLD_LAST = HW'(RST_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST  = MAX_CYCLES - CNT_WIDTH'(1);

  state_e                  state_q, state_d;
  logic [HW-1:0]           hold_q, hold_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   arg_q, arg_d;
  logic [DATA_WIDTH-1:0]   ret_q, ret_d;
  logic [CNT_WIDTH-1:0]    cyc_q, cyc_d;
  logic                    to_q, to_d;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      cnt_q   <= '0;
      arg_q   <= '0;
      ret_q   <= '0;
      cyc_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      arg_q   <= arg_d;
      ret_q   <= ret_d;
      cyc_q   <= cyc_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    arg_d   = arg_q;
    ret_d   = ret_q;
    cyc_d   = cyc_q;
    to_d    = to_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          arg_d   = req_arg;
          hold_d  = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (hold_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      RUN: begin
        // stop takes priority, so a stop in the last budget cycle reports MAX_CYCLES untimed-out
        if (core_stop) begin
          ret_d   = core_return;
          cyc_d   = cnt_q + CNT_WIDTH'(1);
          to_d    = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          ret_d   = core_return;
          cyc_d   = MAX_CYCLES;
          to_d    = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign core_reset  = (state_q != RUN);
  assign core_arg    = arg_q;
  assign rsp_return  = ret_q;
  assign rsp_cycles  = cyc_q;
  assign rsp_timeout = to_q;

endmodule

// File: tb/tb_shervi_run_ctrl.sv
// Directed bench: instance a uses the default budget, instance b a budget of 8.
module tb_shervi_run_ctrl;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic        reset;
  logic        a_req_valid, a_req_ready, a_core_reset, a_core_stop, a_rsp_valid, a_rsp_ready, a_rsp_timeout, a_busy;
  logic [15:0] a_req_arg, a_core_arg, a_core_return, a_rsp_return;
  logic [23:0] a_rsp_cycles;
  logic        b_req_valid, b_req_ready, b_core_reset, b_core_stop, b_rsp_valid, b_rsp_ready, b_rsp_timeout, b_busy;
  logic [15:0] b_req_arg, b_core_arg, b_core_return, b_rsp_return;
  logic [23:0] b_rsp_cycles;

  shervi_run_ctrl dut_a (
    .CLK(CLK), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_arg(a_req_arg),
    .core_arg(a_core_arg), .core_reset(a_core_reset), .core_return(a_core_return), .core_stop(a_core_stop),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_return(a_rsp_return),
    .rsp_cycles(a_rsp_cycles), .rsp_timeout(a_rsp_timeout), .busy(a_busy)
  );

  shervi_run_ctrl #(.MAX_CYCLES(24'd8)) dut_b (
    .CLK(CLK), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_arg(b_req_arg),
    .core_arg(b_core_arg), .core_reset(b_core_reset), .core_return(b_core_return), .core_stop(b_core_stop),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_return(b_rsp_return),
    .rsp_cycles(b_rsp_cycles), .rsp_timeout(b_rsp_timeout), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    a_req_valid = 0; a_req_arg = '0; a_core_return = '0; a_core_stop = 0; a_rsp_ready = 0;
    b_req_valid = 0; b_req_arg = '0; b_core_return = '0; b_core_stop = 0; b_rsp_ready = 0;
    tick(); tick();

    // reset values
    chk("rst_req_ready", a_req_ready, 1);
    chk("rst_busy", a_busy, 0);
    chk("rst_core_reset", a_core_reset, 1);
    chk("rst_core_arg", a_core_arg, 0);
    chk("rst_rsp_valid", a_rsp_valid, 0);
    chk("rst_rsp_return", a_rsp_return, 0);
    chk("rst_rsp_cycles", a_rsp_cycles, 0);
    chk("rst_rsp_timeout", a_rsp_timeout, 0);
    reset = 1'b1;
    tick();
    chk("post_rst_req_ready", a_req_ready, 1);
    chk("post_rst_core_reset", a_core_reset, 1);

    // basic run: arg 5, stop in RUN cycle 9 with return 0x78
    a_req_arg = 16'h0005; a_req_valid = 1;
    tick();                                   // accept edge T
    a_req_valid = 0;
    chk("basic_hold1_core_reset", a_core_reset, 1);
    chk("basic_hold1_req_ready", a_req_ready, 0);
    chk("basic_hold1_busy", a_busy, 1);
    chk("basic_core_arg", a_core_arg, 16'h0005);
    tick();
    chk("basic_hold2_core_reset", a_core_reset, 1);
    tick();                                   // first RUN cycle
    for (int k = 0; k < 10; k++) begin
      a_core_stop = (k == 9);
      a_core_return = (k == 9) ? 16'h0078 : 16'h0000;
      chk($sformatf("basic_run%0d_core_reset", k), a_core_reset, 0);
      chk($sformatf("basic_run%0d_rsp_valid", k), a_rsp_valid, 0);
      chk($sformatf("basic_run%0d_core_arg", k), a_core_arg, 16'h0005);
      tick();
    end
    a_core_stop = 0;
    chk("basic_rsp_valid", a_rsp_valid, 1);
    chk("basic_rsp_return", a_rsp_return, 16'h0078);
    chk("basic_rsp_cycles", a_rsp_cycles, 10);
    chk("basic_rsp_timeout", a_rsp_timeout, 0);
    chk("basic_done_core_reset", a_core_reset, 1);
    chk("basic_done_core_arg", a_core_arg, 16'h0005);
    a_rsp_ready = 1;
    tick();
    a_rsp_ready = 0;
    chk("basic_idle_rsp_valid", a_rsp_valid, 0);
    chk("basic_idle_req_ready", a_req_ready, 1);
    chk("basic_idle_core_arg", a_core_arg, 16'h0005);

    // stale stop: stop high through HOLD, dropped in first RUN cycle
    a_req_arg = 16'h0003; a_req_valid = 1; a_core_stop = 1;
    tick();
    a_req_valid = 0;
    tick();
    tick();                                   // RUN cycle 0
    a_core_stop = 0;
    chk("stale_run_core_reset", a_core_reset, 0);
    for (int k = 0; k < 5; k++) begin
      a_core_stop = (k == 4);
      a_core_return = (k == 4) ? 16'h1234 : 16'h0000;
      chk($sformatf("stale_run%0d_rsp_valid", k), a_rsp_valid, 0);
      tick();
    end
    a_core_stop = 0;
    chk("stale_rsp_valid", a_rsp_valid, 1);
    chk("stale_rsp_cycles", a_rsp_cycles, 5);
    chk("stale_rsp_return", a_rsp_return, 16'h1234);

    // backpressure: 20 cycles in DONE with req_valid high and stop toggling
    a_req_valid = 1; a_req_arg = 16'h0009;
    for (int i = 0; i < 20; i++) begin
      a_core_stop = i[0];
      a_core_return = 16'(16'hA000 + i);
      chk($sformatf("bp%0d_rsp_valid", i), a_rsp_valid, 1);
      chk($sformatf("bp%0d_rsp_return", i), a_rsp_return, 16'h1234);
      chk($sformatf("bp%0d_rsp_cycles", i), a_rsp_cycles, 5);
      chk($sformatf("bp%0d_rsp_timeout", i), a_rsp_timeout, 0);
      chk($sformatf("bp%0d_req_ready", i), a_req_ready, 0);
      tick();
    end
    a_core_stop = 0;
    a_rsp_ready = 1;
    tick();                                   // response handshake edge D
    a_rsp_ready = 0;
    chk("bp_idle_req_ready", a_req_ready, 1);
    chk("bp_idle_core_arg", a_core_arg, 16'h0003);
    tick();                                   // accept edge D+1
    a_req_valid = 0;
    chk("bp_accept_busy", a_busy, 1);
    chk("bp_accept_core_arg", a_core_arg, 16'h0009);
    tick();
    tick();                                   // RUN cycle 0

    // asynchronous reset mid-RUN at count 37
    for (int k = 0; k < 37; k++) tick();
    chk("mid_run_core_reset", a_core_reset, 0);
    #1 reset = 1'b0;
    #1;
    chk("async_rst_rsp_valid", a_rsp_valid, 0);
    chk("async_rst_core_reset", a_core_reset, 1);
    chk("async_rst_req_ready", a_req_ready, 1);
    chk("async_rst_busy", a_busy, 0);
    chk("async_rst_core_arg", a_core_arg, 0);
    chk("async_rst_rsp_cycles", a_rsp_cycles, 0);
    tick();
    reset = 1'b1;
    tick();
    a_req_arg = 16'h0007; a_req_valid = 1;
    tick();
    a_req_valid = 0;
    chk("after_rst_core_arg", a_core_arg, 16'h0007);
    tick();
    tick();
    a_core_stop = 1; a_core_return = 16'h00AA;
    tick();
    a_core_stop = 0;
    chk("after_rst_rsp_valid", a_rsp_valid, 1);
    chk("after_rst_rsp_cycles", a_rsp_cycles, 1);
    chk("after_rst_rsp_return", a_rsp_return, 16'h00AA);

    // timeout on budget of 8, core never stops
    b_req_arg = 16'h0001; b_req_valid = 1; b_core_return = 16'hBEEF;
    tick();
    b_req_valid = 0;
    tick();
    tick();
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("to_run%0d_core_reset", k), b_core_reset, 0);
      chk($sformatf("to_run%0d_rsp_valid", k), b_rsp_valid, 0);
      tick();
    end
    chk("to_rsp_valid", b_rsp_valid, 1);
    chk("to_rsp_timeout", b_rsp_timeout, 1);
    chk("to_rsp_cycles", b_rsp_cycles, 8);
    chk("to_rsp_return", b_rsp_return, 16'hBEEF);
    chk("to_done_core_reset", b_core_reset, 1);
    tick();
    chk("to_done2_core_reset", b_core_reset, 1);
    b_rsp_ready = 1;
    tick();
    b_rsp_ready = 0;
    chk("to_idle_core_reset", b_core_reset, 1);

    // stop coinciding with budget expiry
    b_req_arg = 16'h0002; b_req_valid = 1; b_core_return = 16'h0000;
    tick();
    b_req_valid = 0;
    tick();
    tick();
    for (int k = 0; k < 8; k++) begin
      b_core_stop = (k == 7);
      b_core_return = (k == 7) ? 16'h0055 : 16'h0000;
      tick();
    end
    b_core_stop = 0;
    chk("sim_rsp_valid", b_rsp_valid, 1);
    chk("sim_rsp_timeout", b_rsp_timeout, 0);
    chk("sim_rsp_cycles", b_rsp_cycles, 8);
    chk("sim_rsp_return", b_rsp_return, 16'h0055);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
